vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator. It runs on the system clock with an internal pixel-rate clock enable instead of a derived clock. All horizontal and vertical timing, sync polarity, colour depth and clock division are parameters. It presents look-ahead pixel coordinates to the upstream colour source, then emits registered, aligned sync, data-enable, colour and frame/line markers to the DAC pins.

## Interface
Parameters:
- CLK_DIV, 2: system clocks per pixel (≥1)
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- HS_POL, 0: hsync asserted level (0 = active-low)
- VS_POL, 0: vsync asserted level
- CDW, 1: bits per colour channel
- CW, 11: coordinate/counter width. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise must fit in CW bits.

Ports:
- clock, in, 1: system clock, all logic on rising edge
- reset, in, 1: synchronous, active-low
- iCrvgaR/iCrvgaG/iCrvgaB, in, CDW each: colour for the pixel at oCurrentCol/oCurrentRow
- oCrvgaR/oCrvgaG/oCrvgaB, out, CDW each: registered colour, zero outside active area
- hoz_sync / ver_sync, out, 1: sync outputs at configured polarity
- oDe, out, 1: data enable, high while stage-2 pixel is active
- oCurrentCol / oCurrentRow, out, CW each: stage-1 counter values (look-ahead coordinates)
- oReq, out, 1: stage-1 pixel is inside the active area
- oFrameStart, out, 1: one-clock pulse when stage 2 shows pixel (0,0)
- oLineStart, out, 1: one-clock pulse when stage 2 shows column 0 of any active row
- oPixTick, out, 1: pixel clock enable (combinational from prescaler)

## Operation
- Prescaler div_cnt counts 0..CLK_DIV-1 and wraps. oPixTick = (div_cnt == CLK_DIV-1). With CLK_DIV=1, oPixTick is constantly 1 out of reset.
- All state below updates only on edges where oPixTick=1.
- Stage 0 (h_cnt, v_cnt):
  - h_cnt wraps H_TOTAL-1→0.
  - v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1→0.
- Line layout: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical uses the same order in lines.
- Stage 1 loads from stage 0:
  - oCurrentCol=h_cnt and oCurrentRow=v_cnt, raw values, not zeroed in blanking.
  - oReq = (h_cnt<H_ACTIVE)&(v_cnt<V_ACTIVE).
  - h-sync and v-sync decode flags.
- Stage 2 loads from stage 1:
  - oDe = oReq.
  - Colour = oReq ? iCrvga* : 0.
  - hoz_sync = hflag ? HS_POL : ~HS_POL. ver_sync is decoded the same way with VS_POL. vsync spans whole lines.
  - oFrameStart/oLineStart are set on that edge from stage-1 coordinates and cleared on the next clock edge. Each is exactly one system clock wide regardless of CLK_DIV.
- The upstream source has one full pixel period (CLK_DIV clocks) to produce colour for the presented coordinates. It may be combinational.

## Timing
- Reset (reset=0 at an edge) forces:
  - div_cnt, h_cnt, v_cnt, all coordinates, oReq, oDe, colours, oFrameStart and oLineStart to 0.
  - Syncs to their inactive level.
  - This applies mid-frame too and takes effect on the next edge.
- The first tick is the CLK_DIV-th edge with reset=1. That edge loads (0,0) into stage 1 (oReq=1).
- The second tick loads stage 2, giving oDe=1 and oFrameStart=1. Coordinate-to-pin latency is exactly one pixel (CLK_DIV clocks).
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clocks. The default 640×480 at 50 MHz gives 800·525·2 clocks.
- Wrap at (H_TOTAL-1, V_TOTAL-1): the next tick gives stage 0 (0,0). There are no skipped or duplicated pixels.

## Test plan
All scenarios use small timing: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=2, CDW=1.
- Reset release, iCrvgaR=oCurrentCol[0] -> oDe and oFrameStart rise after 4th edge; oFrameStart high 1 clock; oCrvgaR pattern 0,1,0,1… for 8 pixels (16 clocks) then 0.
- Free-run 3 frames -> hoz_sync low for 6 clocks starting 20 clocks after each oLineStart; ver_sync low for 64 clocks per frame; oFrameStart period exactly 256 clocks; oLineStart 4 per frame, 32 clocks apart.
- iCrvga* held 1 during blanking -> outputs 0 whenever oDe=0; oReq leads oDe by exactly 2 clocks.
- Assert reset for 1 clock mid-line (h_cnt=5, v_cnt=2) -> next edge all outputs at reset values, syncs high; after release, same sequence as scenario 1.
- CLK_DIV=1, HS_POL=1, VS_POL=1 -> oPixTick constant 1; oDe first high after 2nd edge; hoz_sync high for 3 clocks per 16; frame period 128 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen : VGA sync/DE/colour timing driven by a pixel-rate clock enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CDW      = 1,
  parameter int CW       = 11
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [CDW-1:0] iCrvgaR,
  input  logic [CDW-1:0] iCrvgaG,
  input  logic [CDW-1:0] iCrvgaB,
  output logic [CDW-1:0] oCrvgaR,
  output logic [CDW-1:0] oCrvgaG,
  output logic [CDW-1:0] oCrvgaB,
  output logic           hoz_sync,
  output logic           ver_sync,
  output logic           oDe,
  output logic [CW-1:0]  oCurrentCol,
  output logic [CW-1:0]  oCurrentRow,
  output logic           oReq,
  output logic           oFrameStart,
  output logic           oLineStart,
  output logic           oPixTick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] c_div_last  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_h_last    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] c_v_last    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] c_h_active  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] c_v_active  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] c_hs_start  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] c_hs_end    = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] c_vs_start  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] c_vs_end    = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          c_hs_on     = 1'(HS_POL);
  localparam logic          c_vs_on     = 1'(VS_POL);

  // Prescaler and stage 0 raster counters
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          w_tick;

  // Stage 1 (look-ahead) and stage 2 (pin) registers
  logic [CW-1:0]  col_q, row_q;
  logic           req_q, hflag_q, vflag_q;
  logic           de_q, hs_q, vs_q, fs_q, ls_q;
  logic [CDW-1:0] r_q, g_q, b_q;

  logic           w_req_d, w_hflag_d, w_vflag_d;

  assign w_tick = (div_cnt_q == c_div_last);

  always_comb begin
    div_cnt_d = (div_cnt_q == c_div_last) ? '0 : div_cnt_q + 1'b1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (h_cnt_q == c_h_last) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == c_v_last) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_comb begin
    w_req_d   = (h_cnt_q < c_h_active) && (v_cnt_q < c_v_active);
    w_hflag_d = (h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end);
    w_vflag_d = (v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      col_q     <= '0;
      row_q     <= '0;
      req_q     <= 1'b0;
      hflag_q   <= 1'b0;
      vflag_q   <= 1'b0;
      de_q      <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= ~c_hs_on;
      vs_q      <= ~c_vs_on;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      // Markers are one system clock wide, so they drop on every non-tick edge
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
      if (w_tick) begin
        h_cnt_q <= h_cnt_d;
        v_cnt_q <= v_cnt_d;

        col_q   <= h_cnt_q;
        row_q   <= v_cnt_q;
        req_q   <= w_req_d;
        hflag_q <= w_hflag_d;
        vflag_q <= w_vflag_d;

        de_q    <= req_q;
        r_q     <= req_q ? iCrvgaR : '0;
        g_q     <= req_q ? iCrvgaG : '0;
        b_q     <= req_q ? iCrvgaB : '0;
        hs_q    <= hflag_q ? c_hs_on : ~c_hs_on;
        vs_q    <= vflag_q ? c_vs_on : ~c_vs_on;
        fs_q    <= req_q && (col_q == '0) && (row_q == '0);
        ls_q    <= req_q && (col_q == '0);
      end
    end
  end

  assign oPixTick    = w_tick;
  assign oCurrentCol = col_q;
  assign oCurrentRow = row_q;
  assign oReq        = req_q;
  assign oDe         = de_q;
  assign oCrvgaR     = r_q;
  assign oCrvgaG     = g_q;
  assign oCrvgaB     = b_q;
  assign hoz_sync    = hs_q;
  assign ver_sync    = vs_q;
  assign oFrameStart = fs_q;
  assign oLineStart  = ls_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen : scoreboard bench for two vga_timing_gen configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int CW = 8;

  typedef struct packed {
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          req;
    logic          de;
    logic [2:0]    rgb;
    logic          hs;
    logic          vs;
    logic          fs;
    logic          ls;
    logic          tick;
  } exp_t;

  logic       clk;
  logic       rstA, rstB;
  logic [2:0] rgb;

  logic [CW-1:0] colA, rowA, colB, rowB;
  logic [0:0]    rA, gA, bA, rB, gB, bB;
  logic          hsA, vsA, deA, reqA, fsA, lsA, tkA;
  logic          hsB, vsB, deB, reqB, fsB, lsB, tkB;

  int compared = 0;
  int mismatched = 0;

  exp_t qA[$];
  exp_t qB[$];
  int   tA = 0, tB = 0;
  int   rstcntA = 0, rstcntB = 0;
  logic [2:0] smpA = '0, smpB = '0;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .CDW(1), .CW(CW)
  ) dut_a (
    .clock(clk), .reset(rstA),
    .iCrvgaR(rgb[2:2]), .iCrvgaG(rgb[1:1]), .iCrvgaB(rgb[0:0]),
    .oCrvgaR(rA), .oCrvgaG(gA), .oCrvgaB(bA),
    .hoz_sync(hsA), .ver_sync(vsA), .oDe(deA),
    .oCurrentCol(colA), .oCurrentRow(rowA), .oReq(reqA),
    .oFrameStart(fsA), .oLineStart(lsA), .oPixTick(tkA)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .CDW(1), .CW(CW)
  ) dut_b (
    .clock(clk), .reset(rstB),
    .iCrvgaR(rgb[2:2]), .iCrvgaG(rgb[1:1]), .iCrvgaB(rgb[0:0]),
    .oCrvgaR(rB), .oCrvgaG(gB), .oCrvgaB(bB),
    .hoz_sync(hsB), .ver_sync(vsB), .oDe(deB),
    .oCurrentCol(colB), .oCurrentRow(rowB), .oReq(reqB),
    .oFrameStart(fsB), .oLineStart(lsB), .oPixTick(tkB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: t edges since reset release, n = t/d pixel ticks; stage 1
  // shows pixel n-1 of the raster, stage 2 shows pixel n-2.
  function automatic exp_t ref_model(int t, int d, bit hp, bit vp, logic [2:0] c);
    exp_t e;
    int   n, p, x, y;
    bit   act;
    e      = '0;
    e.hs   = ~hp;
    e.vs   = ~vp;
    e.tick = ((t % d) == d - 1);
    n      = t / d;
    if (n >= 1) begin
      p     = n - 1;
      x     = p % HT;
      y     = (p / HT) % VT;
      e.col = CW'(x);
      e.row = CW'(y);
      e.req = (x < HA) && (y < VA);
    end
    if (n >= 2) begin
      p     = n - 2;
      x     = p % HT;
      y     = (p / HT) % VT;
      act   = (x < HA) && (y < VA);
      e.de  = act;
      e.rgb = act ? c : 3'b000;
      e.hs  = (x >= HA + HF && x < HA + HF + HS) ? hp : ~hp;
      e.vs  = (y >= VA + VF && y < VA + VF + VS) ? vp : ~vp;
      if (t % d == 0) begin
        e.fs = act && x == 0 && y == 0;
        e.ls = act && x == 0;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected responses are produced at each active edge from the sampled stimulus
  always @(posedge clk) begin
    if (!rstA) begin
      tA = 0; smpA = '0; rstcntA++;
    end else begin
      tA++;
      if (tA % 2 == 0) smpA = rgb;
    end
    qA.push_back(ref_model(tA, 2, 1'b0, 1'b0, smpA));

    if (!rstB) begin
      tB = 0; smpB = '0; rstcntB++;
    end else begin
      tB++;
      smpB = rgb;
    end
    qB.push_back(ref_model(tB, 1, 1'b1, 1'b1, smpB));
  end

  // Monitor: pops one expectation per DUT per clock, away from the active edge
  initial begin
    exp_t e;
    int cyc = 0;
    int lastA = -1, lastB = -1, lrA = -1, lrB = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (qA.size() == 0 || qB.size() == 0) begin
        chk("scoreboard_empty", 32'(qA.size() == 0 || qB.size() == 0), 32'd0);
      end else begin
        e = qA.pop_front();
        chk("A_col",  32'(colA), 32'(e.col));
        chk("A_row",  32'(rowA), 32'(e.row));
        chk("A_req",  32'(reqA), 32'(e.req));
        chk("A_de",   32'(deA),  32'(e.de));
        chk("A_rgb",  32'({rA, gA, bA}), 32'(e.rgb));
        chk("A_hs",   32'(hsA),  32'(e.hs));
        chk("A_vs",   32'(vsA),  32'(e.vs));
        chk("A_fs",   32'(fsA),  32'(e.fs));
        chk("A_ls",   32'(lsA),  32'(e.ls));
        chk("A_tick", 32'(tkA),  32'(e.tick));
        e = qB.pop_front();
        chk("B_col",  32'(colB), 32'(e.col));
        chk("B_row",  32'(rowB), 32'(e.row));
        chk("B_req",  32'(reqB), 32'(e.req));
        chk("B_de",   32'(deB),  32'(e.de));
        chk("B_rgb",  32'({rB, gB, bB}), 32'(e.rgb));
        chk("B_hs",   32'(hsB),  32'(e.hs));
        chk("B_vs",   32'(vsB),  32'(e.vs));
        chk("B_fs",   32'(fsB),  32'(e.fs));
        chk("B_ls",   32'(lsB),  32'(e.ls));
        chk("B_tick", 32'(tkB),  32'(e.tick));
      end
      if (fsA === 1'b1) begin
        if (lastA >= 0 && lrA == rstcntA) chk("A_frame_period", 32'(cyc - lastA), 32'd256);
        lastA = cyc; lrA = rstcntA;
      end
      if (fsB === 1'b1) begin
        if (lastB >= 0 && lrB == rstcntB) chk("B_frame_period", 32'(cyc - lastB), 32'd128);
        lastB = cyc; lrB = rstcntB;
      end
    end
  end

  // Random colour source, changed just after every active edge
  initial begin
    rgb = '0;
    forever begin
      @(posedge clk);
      #1 rgb = 3'($urandom);
    end
  end

  initial begin
    bit found;
    rstA = 1'b0;
    rstB = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstA = 1'b1; rstB = 1'b1;
    repeat (800) @(posedge clk);

    // Mid-line reset of the divided instance with stage 0 at column 5, row 2
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (tA % 256 == 74) begin
        found = 1'b1;
        break;
      end
    end
    chk("A_midline_reset_reached", 32'(found), 32'd1);
    rstA = 1'b0;
    @(posedge clk);
    #1 rstA = 1'b1;
    repeat (600) @(posedge clk);

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(100, 400)) @(posedge clk);
      #1 rstA = 1'b0;
      rstB = ($urandom % 2 == 0) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1 rstA = 1'b1; rstB = 1'b1;
    end
    repeat (600) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
